// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with hold, bubble, saturating Tnew countdown,
// a forwarding-ready flag and a stall-cycle counter. Define EXC_PIPE_EN to carry exception code / branch-delay.

module ex_mem_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + W'(1);
    end
endmodule

module ex_mem_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int TNEW_W  = 2,
    parameter int LOP_W   = 3,
    parameter int MW_W    = 2,
    parameter int SCNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stallM,
    input  logic               flushM,
    input  logic               validE,
    input  logic               regWriteE,
    input  logic               memToRegE,
    input  logic               jalOpE,
    input  logic [MW_W-1:0]    memWriteE,
    input  logic [LOP_W-1:0]   lOpE,
    input  logic [DATA_W-1:0]  aluOutE,
    input  logic [DATA_W-1:0]  rd2True,
    input  logic [DATA_W-1:0]  pcE,
    input  logic [RADDR_W-1:0] writeRegE,
    input  logic [RADDR_W-1:0] rtE,
    input  logic [TNEW_W-1:0]  TnewE,
`ifdef EXC_PIPE_EN
    input  logic [4:0]         excCodeE,
    input  logic               bdE,
    output logic [4:0]         excCodeM,
    output logic               bdM,
`endif
    output logic               validM,
    output logic               regWriteM,
    output logic               memToRegM,
    output logic               jalOpM,
    output logic [MW_W-1:0]    memWriteM,
    output logic [LOP_W-1:0]   lOpM,
    output logic [DATA_W-1:0]  aluOutM,
    output logic [DATA_W-1:0]  writeDataM,
    output logic [DATA_W-1:0]  pcM,
    output logic [RADDR_W-1:0] writeRegM,
    output logic [RADDR_W-1:0] rtM,
    output logic [TNEW_W-1:0]  TnewM,
    output logic               fwdReadyM,
    output logic [SCNT_W-1:0]  stallCnt
);
    typedef struct packed {
        logic               valid;
        logic               reg_write;
        logic               mem_to_reg;
        logic               jal_op;
        logic [MW_W-1:0]    mem_write;
        logic [LOP_W-1:0]   lop;
        logic [DATA_W-1:0]  alu_out;
        logic [DATA_W-1:0]  write_data;
        logic [DATA_W-1:0]  pc;
        logic [RADDR_W-1:0] write_reg;
        logic [RADDR_W-1:0] rt;
        logic [TNEW_W-1:0]  tnew;
    } stage_t;

    stage_t cur, load_val, bubble_val;
    logic   take_bubble, take_load;

    // An upstream bubble on a load edge is squashed like a flush so it never carries side effects.
    assign take_bubble = flushM || (!stallM && !validE);
    assign take_load   = !flushM && !stallM && validE;

    always_comb begin
        load_val            = '0;
        load_val.valid      = validE;
        load_val.reg_write  = regWriteE;
        load_val.mem_to_reg = memToRegE;
        load_val.jal_op     = jalOpE;
        load_val.mem_write  = memWriteE;
        load_val.lop        = lOpE;
        load_val.alu_out    = aluOutE;
        load_val.write_data = rd2True;
        load_val.pc         = pcE;
        load_val.write_reg  = writeRegE;
        load_val.rt         = rtE;
        load_val.tnew       = (TnewE == '0) ? '0 : TnewE - TNEW_W'(1);

        bubble_val          = '0;
        bubble_val.pc       = pcE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cur <= '0;
        else if (take_bubble)
            cur <= bubble_val;
        else if (take_load)
            cur <= load_val;
    end

`ifdef EXC_PIPE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            excCodeM <= '0;
            bdM      <= 1'b0;
        end else if (take_bubble) begin
            excCodeM <= '0;
            bdM      <= bdE;
        end else if (take_load) begin
            excCodeM <= excCodeE;
            bdM      <= bdE;
        end
    end
`endif

    ex_mem_sat_cnt #(.W(SCNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stallM && !flushM),
        .cnt   (stallCnt)
    );

    assign validM     = cur.valid;
    assign regWriteM  = cur.reg_write;
    assign memToRegM  = cur.mem_to_reg;
    assign jalOpM     = cur.jal_op;
    assign memWriteM  = cur.mem_write;
    assign lOpM       = cur.lop;
    assign aluOutM    = cur.alu_out;
    assign writeDataM = cur.write_data;
    assign pcM        = cur.pc;
    assign writeRegM  = cur.write_reg;
    assign rtM        = cur.rt;
    assign TnewM      = cur.tnew;

    // Register $0 is never a forwarding source.
    assign fwdReadyM = cur.valid && cur.reg_write && (cur.tnew == '0) && (cur.write_reg != '0);

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: stimulus pushes model predictions, a monitor compares after each edge.
// Also exercises EXC_PIPE_EN ports when that macro is defined.

module tb_ex_mem_pipe_reg;
    localparam int SCNT_W = 4;

    logic        clk = 0, reset = 1;
    logic        stallM = 0, flushM = 0, validE = 0;
    logic        regWriteE = 0, memToRegE = 0, jalOpE = 0;
    logic [1:0]  memWriteE = 0;
    logic [2:0]  lOpE = 0;
    logic [31:0] aluOutE = 0, rd2True = 0, pcE = 0;
    logic [4:0]  writeRegE = 0, rtE = 0;
    logic [1:0]  TnewE = 0;
    logic        validM, regWriteM, memToRegM, jalOpM, fwdReadyM;
    logic [1:0]  memWriteM, TnewM;
    logic [2:0]  lOpM;
    logic [31:0] aluOutM, writeDataM, pcM;
    logic [4:0]  writeRegM, rtM;
    logic [SCNT_W-1:0] stallCnt;
`ifdef EXC_PIPE_EN
    logic [4:0]  excCodeE = 0, excCodeM;
    logic        bdE = 0, bdM;
`endif

    ex_mem_pipe_reg #(.SCNT_W(SCNT_W)) dut (
        .clk(clk), .reset(reset), .stallM(stallM), .flushM(flushM), .validE(validE),
        .regWriteE(regWriteE), .memToRegE(memToRegE), .jalOpE(jalOpE), .memWriteE(memWriteE),
        .lOpE(lOpE), .aluOutE(aluOutE), .rd2True(rd2True), .pcE(pcE), .writeRegE(writeRegE),
        .rtE(rtE), .TnewE(TnewE),
`ifdef EXC_PIPE_EN
        .excCodeE(excCodeE), .bdE(bdE), .excCodeM(excCodeM), .bdM(bdM),
`endif
        .validM(validM), .regWriteM(regWriteM), .memToRegM(memToRegM), .jalOpM(jalOpM),
        .memWriteM(memWriteM), .lOpM(lOpM), .aluOutM(aluOutM), .writeDataM(writeDataM),
        .pcM(pcM), .writeRegM(writeRegM), .rtM(rtM), .TnewM(TnewM), .fwdReadyM(fwdReadyM),
        .stallCnt(stallCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, rw, m2r, jal;
        logic [1:0]  mw, tnew;
        logic [2:0]  lop;
        logic [31:0] alu, wd, pc;
        logic [4:0]  wr, rt, exc;
        logic        bd;
        int          scnt;
    } exp_t;

    exp_t m, q[$];
    int   vectors = 0, miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, want);
        end
    endtask

    task automatic compare(input exp_t e);
        logic fwd;
        fwd = e.valid && e.rw && (e.tnew == 0) && (e.wr != 0);
        chk("validM", 32'(validM), 32'(e.valid));
        chk("regWriteM", 32'(regWriteM), 32'(e.rw));
        chk("memToRegM", 32'(memToRegM), 32'(e.m2r));
        chk("jalOpM", 32'(jalOpM), 32'(e.jal));
        chk("memWriteM", 32'(memWriteM), 32'(e.mw));
        chk("lOpM", 32'(lOpM), 32'(e.lop));
        chk("aluOutM", aluOutM, e.alu);
        chk("writeDataM", writeDataM, e.wd);
        chk("pcM", pcM, e.pc);
        chk("writeRegM", 32'(writeRegM), 32'(e.wr));
        chk("rtM", 32'(rtM), 32'(e.rt));
        chk("TnewM", 32'(TnewM), 32'(e.tnew));
        chk("fwdReadyM", 32'(fwdReadyM), 32'(fwd));
        chk("stallCnt", 32'(stallCnt), 32'(e.scnt));
`ifdef EXC_PIPE_EN
        chk("excCodeM", 32'(excCodeM), 32'(e.exc));
        chk("bdM", 32'(bdM), 32'(e.bd));
`endif
    endtask

    // Monitor: the register presents a new value after every non-reset edge.
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) compare(q.pop_front());
    end

    function automatic exp_t zero_state();
        exp_t z;
        z = '{default: '0};
        z.scnt = 0;
        return z;
    endfunction

    // Reference: outcome of one edge from the current inputs, by priority flush > stall > load.
    task automatic predict();
        exp_t n;
        n = m;
        if (flushM || (!stallM && !validE)) begin
            n      = zero_state();
            n.pc   = pcE;
            n.bd   = `ifdef EXC_PIPE_EN bdE `else 1'b0 `endif;
            n.scnt = m.scnt;
        end else if (!stallM) begin
            n.valid = 1; n.rw = regWriteE; n.m2r = memToRegE; n.jal = jalOpE;
            n.mw = memWriteE; n.lop = lOpE; n.alu = aluOutE; n.wd = rd2True; n.pc = pcE;
            n.wr = writeRegE; n.rt = rtE;
            n.tnew = (TnewE == 0) ? 2'd0 : 2'(int'(TnewE) - 1);
`ifdef EXC_PIPE_EN
            n.exc = excCodeE; n.bd = bdE;
`endif
        end
        if (stallM && !flushM && m.scnt < (1 << SCNT_W) - 1) n.scnt = m.scnt + 1;
        m = n;
        q.push_back(n);
    endtask

    task automatic randomize_inputs();
        validE = ($urandom_range(0, 9) != 0);
        regWriteE = 1'($urandom); memToRegE = 1'($urandom); jalOpE = 1'($urandom);
        memWriteE = 2'($urandom); lOpE = 3'($urandom);
        aluOutE = $urandom; rd2True = $urandom; pcE = $urandom;
        writeRegE = 5'($urandom); rtE = 5'($urandom); TnewE = 2'($urandom);
`ifdef EXC_PIPE_EN
        excCodeE = 5'($urandom); bdE = 1'($urandom);
`endif
    endtask

    // Inputs change at the falling edge, prediction is queued for the next rising edge.
    task automatic step(input logic st, input logic fl);
        stallM = st; flushM = fl;
        predict();
        @(negedge clk);
    endtask

    task automatic load(input logic [4:0] wr, input logic [31:0] alu, input logic [1:0] tn);
        randomize_inputs();
        validE = 1; regWriteE = 1; writeRegE = wr; aluOutE = alu; TnewE = tn;
        step(0, 0);
    endtask

    initial begin
        m = zero_state();
        @(negedge clk); @(negedge clk);
        compare(m);
        reset = 0;

        load(5'd8, 32'h1234, 2'd2);
        load(5'd8, 32'h1234, 2'd1);
        load(5'd8, 32'h1234, 2'd0);

        // Asynchronous reset between edges from a nonzero state.
        load(5'd9, 32'hDEAD_BEEF, 2'd0);
        stallM = 1; step(1, 0);
        #2 reset = 1;
        #1 m = zero_state();
        compare(m);
        @(negedge clk);
        reset = 0;

        load(5'd3, 32'hAAAA, 2'd3);
        aluOutE = 32'h5555;
        repeat (3) step(1, 0);

        pcE = 32'h3004;
        step(1, 1);

        randomize_inputs();
        validE = 1; regWriteE = 1; writeRegE = 0; TnewE = 0;
        step(0, 0);
        randomize_inputs();
        validE = 0; memWriteE = 2'd1;
        step(0, 0);

        repeat (20) step(1, 0);

`ifdef EXC_PIPE_EN
        randomize_inputs();
        validE = 1; excCodeE = 5'd4; bdE = 1;
        step(0, 0);
        bdE = 1;
        step(0, 1);
`endif

        for (int i = 0; i < 600; i++) begin
            randomize_inputs();
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1;
                #1 m = zero_state();
                q.delete();
                compare(m);
                @(negedge clk);
                randomize_inputs();
                stallM = 1'($urandom); flushM = 0;
                reset = 0;
            end
        end

        @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised EX/MEM pipeline register for the five-stage MIPS core, successor to the fixed-width EX/MEM latch. Captures EX-stage control, ALU result, store data, destination register, PC, load-extension op and hazard countdown, and adds a valid bit, stall (hold), flush (bubble), a saturating Tnew countdown of configurable width, a forwarding-ready flag and a stall-cycle counter. Sits between the ALU/forwarding mux and the data memory.

## Interface
- DATA_W, 32, width of aluOut, writeData and pc
- RADDR_W, 5, register-address width (writeReg, rt)
- TNEW_W, 2, Tnew width
- LOP_W, 3, load-extension op width
- MW_W, 2, memWrite width
- SCNT_W, 16, stall-counter width

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- stallM  in  1  hold all stage contents
- flushM  in  1  load a bubble
- validE  in  1  EX holds a real instruction
- regWriteE, memToRegE, jalOpE  in  1 each  control
- memWriteE  in  MW_W  store type
- lOpE  in  LOP_W  load-extension op
- aluOutE, rd2True, pcE  in  DATA_W  ALU result, forwarded rt data, PC
- writeRegE, rtE  in  RADDR_W  destination, rt
- TnewE  in  TNEW_W  cycles until result ready, counted at EX
- validM, regWriteM, memToRegM, jalOpM  out  1 each
- memWriteM  out  MW_W
- lOpM  out  LOP_W
- aluOutM, writeDataM, pcM  out  DATA_W
- writeRegM, rtM  out  RADDR_W
- TnewM  out  TNEW_W
- fwdReadyM  out  1  result in M is forwardable this cycle
- stallCnt  out  SCNT_W  cycles spent held

## Operation
- Priority per edge: reset > flushM > stallM > load.
- Load: every output register takes its E counterpart (rd2True -> writeDataM, validE -> validM); TnewM <= TnewE==0 ? 0 : TnewE-1 (saturating, never wraps).
- Load with validE=0: same as flush (bubble), so upstream bubbles never carry side effects.
- Flush: validM, regWriteM, memToRegM, jalOpM, memWriteM, lOpM, TnewM, writeRegM, rtM, aluOutM, writeDataM <= 0; pcM <= pcE (bubble keeps a PC).
- Stall: all fields including TnewM hold. flushM with stallM: flush wins.
- fwdReadyM (combinational from registers) = validM & regWriteM & (TnewM==0) & (writeRegM!=0).
- stallCnt increments on each edge where stallM=1 and flushM=0; saturates at all-ones; cleared only by reset.

## Timing
- Latency 1 cycle E -> M. No combinational path input -> output except none; fwdReadyM depends only on registers.
- Reset: every output 0, including pcM and stallCnt; takes effect immediately, not on an edge. Reset released mid-stall: first edge after release obeys stall/flush/load normally.
- Write port $0: writeRegE=0 with regWriteE=1 loads as given; fwdReadyM stays 0.

## Configuration
- EXC_PIPE_EN defined: adds inputs excCodeE[4:0], bdE (branch-delay), outputs excCodeM[4:0], bdM. Load copies them; flush clears excCodeM, keeps bdM<=bdE; stall holds; reset clears. A flush-by-validE=0 also clears excCodeM.
- Undefined: ports absent, no extra state; all other behaviour identical.

## Test plan
- Reset: assert reset mid-cycle with nonzero state -> all outputs 0 before next edge, stallCnt=0.
- Load: regWriteE=1, writeRegE=8, aluOutE=0x1234, TnewE=2 -> next edge validM=1, writeRegM=8, aluOutM=0x1234, TnewM=1, fwdReadyM=0; TnewE=1 -> TnewM=0, fwdReadyM=1; TnewE=0 -> TnewM=0.
- Stall: load aluOutE=0xAAAA, then 3 cycles stallM=1 with aluOutE=0x5555 -> aluOutM stays 0xAAAA, TnewM held, stallCnt=3.
- Flush over stall: stallM=1, flushM=1, pcE=0x3004 -> all controls 0, validM=0, pcM=0x3004, stallCnt unchanged.
- $0 and bubble: regWriteE=1, writeRegE=0, TnewE=0 -> fwdReadyM=0; validE=0 with memWriteE=1 -> memWriteM=0.
- Saturation (SCNT_W=4): hold stallM 20 cycles -> stallCnt=15; with EXC_PIPE_EN, excCodeE=4, bdE=1 then flush -> excCodeM=0, bdM=bdE.
